// File: rtl/io_responder_pkg.sv
// ============================================================================
// Module      : io_responder_pkg
// Description : Shared IO-bus defines: chip/write-enable levels, register
//               word offsets and CTRL/STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_responder_pkg;

    localparam logic c_CE_ACTIVE = 1'b1;
    localparam logic c_WE_WRITE  = 1'b1;
    localparam logic c_WE_READ   = 1'b0;

    typedef logic [5:0] word_off_t;

    localparam word_off_t c_OFF_GPIO_OUT = 6'h00;
    localparam word_off_t c_OFF_GPIO_IN  = 6'h01;
    localparam word_off_t c_OFF_CTRL     = 6'h02;
    localparam word_off_t c_OFF_LOAD     = 6'h03;
    localparam word_off_t c_OFF_COUNT    = 6'h04;
    localparam word_off_t c_OFF_STATUS   = 6'h05;

    localparam int c_CTRL_W           = 4;
    localparam int c_CTRL_EN          = 0;
    localparam int c_CTRL_AUTO_RELOAD = 1;
    localparam int c_CTRL_TIMER_IE    = 2;
    localparam int c_CTRL_GPIO_IE     = 3;

    localparam int c_STAT_W    = 2;
    localparam int c_STAT_TEXP = 0;
    localparam int c_STAT_GCHG = 1;

endpackage

`default_nettype wire

// File: rtl/io_sync.sv
// ============================================================================
// Module      : io_sync
// Description : Multi-stage flop synchronizer for asynchronous board inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/io_responder.sv
// ============================================================================
// Module      : io_responder
// Description : Memory-mapped GPIO + down-counting timer with level IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_responder
    import io_responder_pkg::*;
#(
    parameter int GPIO_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ioCe,
    input  logic              ioWe,
    input  logic [31:0]       ioAddr,
    input  logic [31:0]       ioWtData,
    output logic [31:0]       ioRdData,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              irq
);

    logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d;
    logic [c_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]         load_q, load_d;
    logic [31:0]         count_q, count_d;
    logic [c_STAT_W-1:0] status_q, status_d;
    logic [GPIO_W-1:0]   gpio_prev_q;
    logic                irq_q, irq_d;

    logic [GPIO_W-1:0]   w_gpio_sync;
    logic                w_wr, w_rd;
    word_off_t           w_off;
    logic                w_texp_set, w_gchg_set;
    logic [31:0]         w_gpio_out_ext, w_gpio_in_ext;
    logic                w_unused_addr;

    io_sync #(
        .WIDTH  (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_io_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gpioIn),
        .q_o (w_gpio_sync)
    );

    // Only the word offset is decoded; the top nibble is decoded upstream.
    assign w_off         = ioAddr[7:2];
    assign w_unused_addr = ^{ioAddr[31:8], ioAddr[1:0]};
    assign w_wr          = (ioCe == c_CE_ACTIVE) && (ioWe == c_WE_WRITE);
    assign w_rd          = (ioCe == c_CE_ACTIVE) && (ioWe == c_WE_READ);

    always_comb begin
        w_gpio_out_ext = '0;
        w_gpio_out_ext[GPIO_W-1:0] = gpio_out_q;
        w_gpio_in_ext = '0;
        w_gpio_in_ext[GPIO_W-1:0] = w_gpio_sync;
    end

    // Hardware timer update first; bus writes below override it.
    always_comb begin
        gpio_out_d = gpio_out_q;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        count_d    = count_q;
        status_d   = status_q;
        w_texp_set = 1'b0;
        w_gchg_set = (w_gpio_sync != gpio_prev_q);

        if (ctrl_q[c_CTRL_EN]) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                w_texp_set = 1'b1;
                if (ctrl_q[c_CTRL_AUTO_RELOAD]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[c_CTRL_EN] = 1'b0;
                end
            end
        end

        if (w_wr) begin
            case (w_off)
                c_OFF_GPIO_OUT: gpio_out_d = ioWtData[GPIO_W-1:0];
                c_OFF_CTRL:     ctrl_d     = ioWtData[c_CTRL_W-1:0];
                c_OFF_LOAD: begin
                    load_d  = ioWtData;
                    count_d = ioWtData;
                end
                c_OFF_STATUS:   status_d   = status_q & ~ioWtData[c_STAT_W-1:0];
                default: ;
            endcase
        end

        if (w_texp_set) status_d[c_STAT_TEXP] = 1'b1;
        if (w_gchg_set) status_d[c_STAT_GCHG] = 1'b1;

        irq_d = (status_q[c_STAT_TEXP] & ctrl_q[c_CTRL_TIMER_IE]) |
                (status_q[c_STAT_GCHG] & ctrl_q[c_CTRL_GPIO_IE]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out_q  <= '0;
            ctrl_q      <= '0;
            load_q      <= '0;
            count_q     <= '0;
            status_q    <= '0;
            gpio_prev_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            gpio_out_q  <= gpio_out_d;
            ctrl_q      <= ctrl_d;
            load_q      <= load_d;
            count_q     <= count_d;
            status_q    <= status_d;
            gpio_prev_q <= w_gpio_sync;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        ioRdData = '0;
        if (w_rd) begin
            case (w_off)
                c_OFF_GPIO_OUT: ioRdData = w_gpio_out_ext;
                c_OFF_GPIO_IN:  ioRdData = w_gpio_in_ext;
                c_OFF_CTRL:     ioRdData[c_CTRL_W-1:0] = ctrl_q;
                c_OFF_LOAD:     ioRdData = load_q;
                c_OFF_COUNT:    ioRdData = count_q;
                c_OFF_STATUS:   ioRdData[c_STAT_W-1:0] = status_q;
                default: ;
            endcase
        end
    end

    assign gpioOut = gpio_out_q;
    assign irq     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_responder.sv
// ============================================================================
// Module      : tb_io_responder
// Description : Directed self-checking bench for io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_responder;

    localparam logic [31:0] c_A_GPIO_OUT = 32'h7000_0000;
    localparam logic [31:0] c_A_GPIO_IN  = 32'h7000_0004;
    localparam logic [31:0] c_A_CTRL     = 32'h7000_0008;
    localparam logic [31:0] c_A_LOAD     = 32'h7000_000C;
    localparam logic [31:0] c_A_COUNT    = 32'h7000_0010;
    localparam logic [31:0] c_A_STATUS   = 32'h7000_0014;
    localparam logic [31:0] c_A_UNMAPPED = 32'h7000_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioCe, ioWe;
    logic [31:0] ioAddr, ioWtData, ioRdData;
    logic [15:0] gpioIn, gpioOut;
    logic        irq;

    int total = 0;
    int bad   = 0;

    io_responder #(
        .GPIO_W      (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ioCe     (ioCe),
        .ioWe     (ioWe),
        .ioAddr   (ioAddr),
        .ioWtData (ioWtData),
        .ioRdData (ioRdData),
        .gpioIn   (gpioIn),
        .gpioOut  (gpioOut),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ioCe = 1'b1; ioWe = 1'b1; ioAddr = a; ioWtData = d;
        @(posedge clk);
        #1;
        ioCe = 1'b0; ioWe = 1'b0; ioWtData = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ioCe = 1'b1; ioWe = 1'b0; ioAddr = a;
        #1;
        d = ioRdData;
        ioCe = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; ioCe = 1'b0; ioWe = 1'b0; ioAddr = '0; ioWtData = '0; gpioIn = '0;
        #2;
        total++; if (gpioOut !== 16'h0) begin bad++; $display("FAIL rst_gpioOut got=%h exp=0000", gpioOut); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        total++; if (ioRdData !== 32'h0) begin bad++; $display("FAIL rst_rd_idle got=%h exp=0", ioRdData); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_no_gchg got=%h exp=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq_after got=%b exp=0", irq); end
    endtask

    task automatic test_gpio_out();
        logic [31:0] d;
        @(negedge clk);
        ioCe = 1'b1; ioWe = 1'b1; ioAddr = c_A_GPIO_OUT; ioWtData = 32'hFFFF_A5A5;
        #1;
        total++; if (ioRdData !== 32'h0) begin bad++; $display("FAIL rd_during_write got=%h exp=0", ioRdData); end
        @(posedge clk);
        #1;
        ioCe = 1'b0; ioWe = 1'b0; ioWtData = '0;
        total++; if (gpioOut !== 16'hA5A5) begin bad++; $display("FAIL gpioOut got=%h exp=a5a5", gpioOut); end
        rd(c_A_GPIO_OUT, d);
        total++; if (d !== 32'h0000_A5A5) begin bad++; $display("FAIL gpio_out_rd got=%h exp=0000a5a5", d); end
        rd(c_A_GPIO_OUT | 32'h3, d);
        total++; if (d !== 32'h0000_A5A5) begin bad++; $display("FAIL addr_lsb_ignored got=%h exp=0000a5a5", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        wr(c_A_UNMAPPED, 32'hDEAD_BEEF);
        rd(c_A_UNMAPPED, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", d); end
        rd(c_A_GPIO_OUT, d);
        total++; if (d !== 32'h0000_A5A5) begin bad++; $display("FAIL unmapped_no_alias got=%h exp=0000a5a5", d); end
        wr(c_A_CTRL, 32'hFFFF_FFF0);
        rd(c_A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_upper_zero got=%h exp=0", d); end
        ioAddr = c_A_GPIO_OUT; ioCe = 1'b0; ioWe = 1'b0;
        #1;
        total++; if (ioRdData !== 32'h0) begin bad++; $display("FAIL rd_ce_low got=%h exp=0", ioRdData); end
    endtask

    task automatic test_gpio_irq();
        logic [31:0] d;
        wr(c_A_CTRL, 32'h8);
        @(negedge clk);
        gpioIn = 16'h0003;
        tick();
        rd(c_A_GPIO_IN, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL gpio_in_stage1 got=%h exp=0", d); end
        tick();
        rd(c_A_GPIO_IN, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL gpio_in_sync got=%h exp=3", d); end
        tick();
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL gchg_set got=%h exp=2", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL gpio_irq_early got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL gpio_irq got=%b exp=1", irq); end
        wr(c_A_STATUS, 32'h2);
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL gchg_w1c got=%h exp=0", d); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL gpio_irq_clear got=%b exp=0", irq); end
        @(negedge clk);
        gpioIn = 16'h0000;
        repeat (4) tick();
        wr(c_A_STATUS, 32'h3);
        wr(c_A_CTRL, 32'h0);
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL gpio_cleanup got=%h exp=0", d); end
    endtask

    task automatic test_timer_reload();
        logic [31:0] d;
        logic [31:0] exp_cnt [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
        wr(c_A_LOAD, 32'd3);
        wr(c_A_CTRL, 32'h7);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            rd(c_A_COUNT, d);
            total++; if (d !== exp_cnt[i]) begin bad++; $display("FAIL count_seq[%0d] got=%0d exp=%0d", i, d, exp_cnt[i]); end
        end
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL texp_early got=%h exp=0", d); end
        tick();
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL count_reload got=%0d exp=3", d); end
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL texp_set got=%h exp=1", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL timer_irq_early got=%b exp=0", irq); end
        wr(c_A_STATUS, 32'h1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL timer_irq got=%b exp=1", irq); end
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL texp_w1c got=%h exp=0", d); end
        tick(); tick();
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL period_early got=%h exp=0", d); end
        tick();
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL period4 got=%h exp=1", d); end
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL period_reload got=%0d exp=3", d); end
        wr(c_A_CTRL, 32'h0);
        wr(c_A_STATUS, 32'h3);
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr(c_A_LOAD, 32'd2);
        wr(c_A_CTRL, 32'h1);
        tick(); tick(); tick();
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_texp got=%h exp=1", d); end
        rd(c_A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_en_clr got=%h exp=0", d); end
        tick();
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL oneshot_hold got=%0d exp=0", d); end
        wr(c_A_STATUS, 32'h1);
        // CTRL write coinciding with the hardware EN clear
        wr(c_A_LOAD, 32'd1);
        wr(c_A_CTRL, 32'h1);
        tick();
        wr(c_A_CTRL, 32'h1);
        rd(c_A_CTRL, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL ctrl_wr_wins got=%h exp=1", d); end
        tick();
        rd(c_A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_second_exp got=%h exp=0", d); end
        wr(c_A_STATUS, 32'h1);
    endtask

    task automatic test_set_vs_w1c();
        logic [31:0] d;
        wr(c_A_LOAD, 32'd2);
        wr(c_A_CTRL, 32'h3);
        tick(); tick();
        wr(c_A_STATUS, 32'h1);
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL set_beats_w1c got=%h exp=1", d); end
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL reload_at_w1c got=%0d exp=2", d); end
        wr(c_A_LOAD, 32'd9);
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd9) begin bad++; $display("FAIL load_wins got=%0d exp=9", d); end
        tick();
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd8) begin bad++; $display("FAIL load_then_dec got=%0d exp=8", d); end
        wr(c_A_CTRL, 32'h0);
        wr(c_A_STATUS, 32'h3);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        wr(c_A_GPIO_OUT, 32'h0000_1234);
        wr(c_A_LOAD, 32'd7);
        wr(c_A_CTRL, 32'h5);
        tick(); tick();
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd5) begin bad++; $display("FAIL pre_reset_count got=%0d exp=5", d); end
        rst = 1'b1;
        #1;
        total++; if (gpioOut !== 16'h0) begin bad++; $display("FAIL async_rst_gpioOut got=%h exp=0000", gpioOut); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq got=%b exp=0", irq); end
        for (int i = 0; i < 6; i++) begin
            rd(c_A_GPIO_OUT + 32'(4 * i), d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL async_rst_reg[%0d] got=%h exp=0", i, d); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        rd(c_A_COUNT, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", d); end
        rd(c_A_CTRL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_rst_ctrl got=%h exp=0", d); end
        rd(c_A_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL post_rst_status got=%h exp=0", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL post_rst_irq got=%b exp=0", irq); end
    endtask

    initial begin
        test_reset();
        test_gpio_out();
        test_unmapped();
        test_gpio_irq();
        test_timer_reload();
        test_oneshot();
        test_set_vs_w1c();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
